pwm_ramp_controller: RTL

- Sequences the 10-bit duty command feeding the motor PWM generator.
- Latches targets from the accelerometer filter path and slew-limits duty changes (soft start/stop).
- Passes through zero on sign reversal, forces duty to zero on brake.
- Sits between filter output and PWMGenerator.PWMinput; output uses the same two's-complement encoding.

---
 rtl/pwm_ramp_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pwm_ramp_controller.sv
// Duty-command sequencer: shapes accepted targets and slew-limits the PWM duty toward them.
// Latency: target lands in goal on the accepting edge; duty moves at most pStep per tick.
// Backpressure: target_ready is low while brake is asserted or in BRAKE; those targets are dropped.
`timescale 1ns/1ps
module pwm_ramp_controller #(
  parameter int pTickDiv   = 50000,
  parameter int pStep      = 4,
  parameter int pMaxDuty   = 511,
  parameter int pDeadband  = 12,
  parameter bit pNegEnable = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       enable,
  input  logic       brake,
  input  logic       target_valid,
  input  logic [9:0] target,
  output logic       target_ready,
  output logic [9:0] duty,
  output logic       at_target,
  output logic [1:0] state
);

  localparam int CW = (pTickDiv > 1) ? $clog2(pTickDiv) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(pTickDiv - 1);
  localparam logic signed [10:0] STEP     = 11'(pStep);
  localparam logic signed [10:0] MAXD     = 11'(pMaxDuty);
  localparam logic signed [10:0] DEADB    = 11'(pDeadband);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RAMP  = 2'b01,
    HOLD  = 2'b10,
    BRAKE = 2'b11
  } state_t;

  state_t             st, st_nxt;
  logic signed [10:0] duty_q, duty_nxt;
  logic signed [10:0] goal_q, goal_nxt;
  logic [CW-1:0]      cnt_q, cnt_nxt;
  logic               zhold_q, zhold_nxt;
  logic               at_q, at_nxt;
  logic               accept, tick, reversal;
  logic signed [10:0] tgt_ext, tgt_mag, tgt_cap;
  logic signed [10:0] eg, interim, diff, step_val;

  // Ready is dropped combinationally with brake so a target offered on the braking edge is not handshaken.
  assign target_ready = !brake && (st != BRAKE);
  assign accept       = target_valid && target_ready;
  assign tick         = ((st == RAMP) || (st == HOLD)) && (cnt_q == CNT_LAST);
  assign duty         = duty_q[9:0];
  assign state        = st;
  assign at_target    = at_q;

  // Shape an offered target: sign policy, magnitude clamp, then deadband, all in 11-bit signed.
  always_comb begin
    tgt_ext = {target[9], target};
    tgt_mag = tgt_ext[10] ? -tgt_ext : tgt_ext;
    if (tgt_mag > MAXD) tgt_mag = MAXD;
    if (!pNegEnable && tgt_ext[10]) tgt_cap = '0;
    else if (tgt_mag <= DEADB)      tgt_cap = '0;
    else                            tgt_cap = tgt_ext[10] ? -tgt_mag : tgt_mag;
  end

  // Slew step candidate: head for zero first when the sign must flip, otherwise toward the effective goal.
  always_comb begin
    eg       = enable ? goal_q : '0;
    reversal = (duty_q[10] && !eg[10] && (eg != '0)) ||
               (!duty_q[10] && (duty_q != '0) && eg[10]);
    interim  = reversal ? '0 : eg;
    diff     = interim - duty_q;
    if (zhold_q)            step_val = duty_q;
    else if (diff > STEP)   step_val = duty_q + STEP;
    else if (diff < -STEP)  step_val = duty_q - STEP;
    else                    step_val = interim;
  end

  // Next-state and datapath update; brake overrides everything after the state decode.
  always_comb begin
    st_nxt    = st;
    duty_nxt  = duty_q;
    goal_nxt  = accept ? tgt_cap : goal_q;
    cnt_nxt   = '0;
    zhold_nxt = 1'b0;
    case (st)
      IDLE: begin
        duty_nxt = '0;
        if (enable) st_nxt = RAMP;
      end
      RAMP: begin
        cnt_nxt   = tick ? '0 : cnt_q + 1'b1;
        zhold_nxt = zhold_q;
        if (tick) begin
          duty_nxt  = step_val;
          // Landing on zero mid-reversal buys exactly one idle tick at zero.
          zhold_nxt = !zhold_q && reversal && (step_val == '0);
          if (step_val == eg) st_nxt = enable ? HOLD : IDLE;
        end
      end
      HOLD: begin
        cnt_nxt = tick ? '0 : cnt_q + 1'b1;
        if (eg != duty_q) st_nxt = RAMP;
      end
      BRAKE: begin
        duty_nxt = '0;
        if (!brake) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
    if (brake) begin
      st_nxt    = BRAKE;
      duty_nxt  = '0;
      cnt_nxt   = '0;
      zhold_nxt = 1'b0;
    end
    at_nxt = (duty_nxt == (enable ? goal_nxt : '0));
  end

  // State register with asynchronous reset straight to a zero duty.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      st      <= IDLE;
      duty_q  <= '0;
      goal_q  <= '0;
      cnt_q   <= '0;
      zhold_q <= 1'b0;
      at_q    <= 1'b1;
    end else begin
      st      <= st_nxt;
      duty_q  <= duty_nxt;
      goal_q  <= goal_nxt;
      cnt_q   <= cnt_nxt;
      zhold_q <= zhold_nxt;
      at_q    <= at_nxt;
    end
  end

endmodule
